// File: rtl/mod_add_stream_ctrl.sv
// Word-serial load / compute / drain wrapper around the 384-bit BLS12-381 field adder.
// Optional operand range check is built when MOD_ADD_RANGE_CHECK_EN is defined.
module mod_add_stream_ctrl #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         range_err,
    output logic [1:0]   state_dbg
);
    localparam int NB = 384;
    localparam int NW = NB / W;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam int BW = $clog2(NB);
    localparam logic [CW-1:0] LAST_CNT = CW'(NW - 1);
    localparam logic [NB-1:0] M =
        384'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

    typedef enum logic [1:0] {
        LOAD_X  = 2'd0,
        LOAD_Y  = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [BW-1:0] word_lsb;
    logic          at_last;
    logic          in_hs;
    logic          out_hs;

    logic [NB-1:0] x_q;
    logic [NB-1:0] y_q;
    logic [NB-1:0] res_q;

    logic          add_carry;
    logic [NB-1:0] add_sum;
    logic          sub_borrow;
    logic [NB-1:0] sub_diff;
    logic [NB-1:0] sum_mod;

    // Handshakes: a word moves on a rising edge exactly when valid && ready are
    // both high in that cycle; valid never waits on ready, and data/last are
    // held stable by the sender while valid is high and ready is low.
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign at_last   = (cnt == LAST_CNT);
    assign word_lsb  = BW'(cnt) * BW'(W);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD_X;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        unique case (state)
            LOAD_X: begin
                in_ready = 1'b1;
                if (in_valid && at_last) state_nxt = LOAD_Y;
            end
            LOAD_Y: begin
                in_ready = 1'b1;
                if (in_valid && at_last) state_nxt = COMPUTE;
            end
            COMPUTE: begin
                state_nxt = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = res_q[word_lsb +: W];
                out_last  = at_last;
                if (out_ready && at_last) state_nxt = LOAD_X;
            end
            default: begin
                state_nxt = LOAD_X;
            end
        endcase
    end

    // The word index restarts at zero on every phase change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if (in_hs || out_hs) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            res_q <= '0;
        end else begin
            if (in_hs && (state == LOAD_X)) x_q[word_lsb +: W] <= in_data;
            if (in_hs && (state == LOAD_Y)) y_q[word_lsb +: W] <= in_data;
            if (state == COMPUTE)           res_q <= sum_mod;
        end
    end

    // Field adder: take s - M when the add overflowed 384 bits or s >= M.
    assign {add_carry, add_sum}   = {1'b0, x_q} + {1'b0, y_q};
    assign {sub_borrow, sub_diff} = {1'b0, add_sum} - {1'b0, M};
    assign sum_mod = (add_carry || !sub_borrow) ? sub_diff : add_sum;

`ifdef MOD_ADD_RANGE_CHECK_EN
    logic [NB-W-1:0] op_low;
    logic [NB-1:0]   op_full;
    logic            range_err_q;

    // The final word is still on in_data, so splice it above the stored words.
    assign op_low  = (state == LOAD_X) ? x_q[NB-W-1:0] : y_q[NB-W-1:0];
    assign op_full = {in_data, op_low};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            range_err_q <= 1'b0;
        end else if (in_hs && at_last && (op_full >= M)) begin
            range_err_q <= 1'b1;
        end
    end

    assign range_err = range_err_q;
`else
    assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_mod_add_stream_ctrl.sv
// Self-checking bench for mod_add_stream_ctrl: directed corner operations, resets,
// range flag, and 1000 randomized operations with stream backpressure.
module tb_mod_add_stream_ctrl;
    localparam int NB = 384;
    localparam int W  = 64;
    localparam int NW = NB / W;
    localparam logic [NB-1:0] M =
        384'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;
`ifdef MOD_ADD_RANGE_CHECK_EN
    localparam logic RC_EXP = 1'b1;
`else
    localparam logic RC_EXP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         range_err;
    logic [1:0]   state_dbg;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    mod_add_stream_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .range_err (range_err),
        .state_dbg (state_dbg)
    );

    task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // reference model: plain modular arithmetic
    function automatic logic [NB-1:0] ref_add(input logic [NB-1:0] a, input logic [NB-1:0] b);
        logic [NB:0] s;
        s = {1'b0, a} + {1'b0, b};
        s = s % {1'b0, M};
        return s[NB-1:0];
    endfunction

    function automatic logic [NB-1:0] rand_op();
        logic [NB-1:0] v;
        for (int i = 0; i < NB / 32; i++) v[i*32 +: 32] = $urandom;
        return v % M;
    endfunction

    // drivers
    task automatic send_word(input logic [W-1:0] w, input bit bp);
        int guard;
        guard = 0;
        if (bp) begin
            while ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom};
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_load", in_ready, 1'b1);
        if (in_ready) begin
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
    endtask

    task automatic load_op(input logic [NB-1:0] x, input logic [NB-1:0] y, input bit bp);
        logic [NB-1:0] z;
        for (int i = 0; i < NW; i++) send_word(x[i*W +: W], bp);
        for (int i = 0; i < NW; i++) send_word(y[i*W +: W], bp);
        z = ref_add(x, y);
        for (int i = 0; i < NW; i++) exp_q.push_back(z[i*W +: W]);
    endtask

    // scoreboard side: accept NW words, checking order, stability and last flag
    task automatic drain_op(input bit bp, input bit check_data);
        int got;
        int guard;
        bit stalled;
        logic [W-1:0] held;
        logic [W-1:0] e;
        got = 0;
        guard = 0;
        stalled = 1'b0;
        held = '0;
        while (got < NW && guard < 500) begin
            out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (bp) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = {$urandom, $urandom};
            end
            if (out_valid) begin
                chk("in_ready_drain", in_ready, 1'b0);
                if (stalled) chk("stall_stable", out_data, held);
                if (out_ready) begin
                    chk("out_last", out_last, (got == NW - 1));
                    e = exp_q.pop_front();
                    if (check_data) chk("out_data", out_data, e);
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = out_data;
                end
            end
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        chk("drain_word_count", got, NW);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("in_ready_after_last", in_ready, 1'b1);
        chk("out_valid_after_last", out_valid, 1'b0);
    endtask

    initial begin
        int guard;
        logic [NB-1:0] m_minus_1;
        logic [NB-1:0] m_minus_5;
        m_minus_1 = M - 384'd1;
        m_minus_5 = M - 384'd5;

        // reset values
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_range_err", range_err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1 + 2 with latency check
        load_op(384'd1, 384'd2, 1'b0);
        chk("compute_out_valid", out_valid, 1'b0);
        chk("compute_in_ready", in_ready, 1'b0);
        @(negedge clk);
        chk("first_out_valid", out_valid, 1'b1);
        drain_op(1'b0, 1'b1);

        // wrap and near-modulus cases
        load_op(m_minus_1, 384'd1, 1'b0);
        drain_op(1'b0, 1'b1);
        load_op(m_minus_1, m_minus_1, 1'b0);
        drain_op(1'b0, 1'b1);
        load_op(m_minus_5, m_minus_5, 1'b0);
        drain_op(1'b0, 1'b1);

        // reset after 3 x words, then a clean 7 + 8
        for (int i = 0; i < 3; i++) send_word({$urandom, $urandom}, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midload_rst_in_ready", in_ready, 1'b1);
        chk("midload_rst_out_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        load_op(384'd7, 384'd8, 1'b0);
        drain_op(1'b0, 1'b1);

        // reset in the middle of a drain drops out_valid without a clock edge
        load_op(rand_op(), rand_op(), 1'b0);
        out_ready = 1'b1;
        guard = 0;
        while (!out_valid && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk("middrain_valid_seen", out_valid, 1'b1);
        for (int i = 0; i < 2; i++) begin
            chk("middrain_data", out_data, exp_q.pop_front());
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("middrain_rst_out_valid", out_valid, 1'b0);
        chk("middrain_rst_out_data", out_data, '0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // range flag: x = M
        for (int i = 0; i < NW - 1; i++) send_word(M[i*W +: W], 1'b0);
        chk("range_before_last", range_err, 1'b0);
        send_word(M[(NW-1)*W +: W], 1'b0);
        chk("range_x_eq_m", range_err, RC_EXP);
        for (int i = 0; i < NW; i++) send_word(W'(5), 1'b0);
        for (int i = 0; i < NW; i++) exp_q.push_back('0);
        drain_op(1'b0, 1'b0);
        chk("range_held", range_err, RC_EXP);
        rst_n = 1'b0;
        @(negedge clk);
        chk("range_cleared_by_rst", range_err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        load_op(m_minus_1, 384'd3, 1'b0);
        drain_op(1'b0, 1'b1);
        chk("range_x_m_minus_1", range_err, 1'b0);

        // randomized operations with backpressure on both streams
        for (int n = 0; n < 1000; n++) begin
            load_op(rand_op(), rand_op(), 1'b1);
            drain_op(1'b1, 1'b1);
        end
        chk("range_after_random", range_err, 1'b0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
